// File: rtl/alu_serie.sv
// alu_serie: bit-serial WIDTH-bit ALU. One full-adder/logic slice is reused
// for every bit, LSB first. Operands are latched on a start handshake, the
// result is assembled in a shift register and published only on completion.
module alu_serie #(
  parameter int WIDTH = 8,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             l,
  input  logic             cin,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  // Operand registers shift right each bit so the slice always sees bit 0.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_l;
  logic [1:0]       r_s;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_out;
  logic             r_c_out;
  logic             r_ovf;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;

  logic             w_x;
  logic             w_y;
  logic             w_sum;
  logic             w_cy;
  logic             w_lbit;
  logic             w_bit;
  logic             w_cnext;
  logic             w_last;
  logic [WIDTH-1:0] w_result;

  // Single bit slice: operand selection, full adder and logic unit.
  always_comb begin
    w_x    = r_a[0];
    w_y    = r_b[0];
    w_lbit = 1'b0;
    case (r_s)
      2'b00: begin
        w_x = r_a[0];
        w_y = r_b[0];
      end
      2'b01: begin
        w_x = r_a[0];
        w_y = ~r_b[0];
      end
      2'b10: begin
        w_x = r_a[0];
        w_y = 1'b0;
      end
      default: begin
        w_x = r_b[0];
        w_y = 1'b0;
      end
    endcase
    w_sum = w_x ^ w_y ^ r_carry;
    w_cy  = (w_x & w_y) | (r_carry & (w_x ^ w_y));
    case (r_s)
      2'b00:   w_lbit = r_a[0] & r_b[0];
      2'b01:   w_lbit = r_a[0] | r_b[0];
      2'b10:   w_lbit = r_a[0] ^ r_b[0];
      default: w_lbit = ~r_a[0];
    endcase
    // Logic mode never produces a carry, so c_out and ovf stay 0 there.
    w_bit    = r_l ? w_lbit : w_sum;
    w_cnext  = r_l ? 1'b0 : w_cy;
    w_last   = (r_cnt == CW'(WIDTH - 1));
    // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    w_result = {w_bit, r_shift[WIDTH-1:1]};
  end

  // Control FSM plus datapath registers; outputs change only on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_l     <= 1'b0;
      r_s     <= 2'b00;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_out   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_l     <= l;
            r_s     <= s;
            r_carry <= cin;
            r_cnt   <= '0;
            r_shift <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_shift <= w_result;
          r_carry <= w_cnext;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_out   <= w_result;
            r_c_out <= w_cnext;
            // Carry into the MSB is r_carry; carry out of it is w_cnext.
            r_ovf   <= r_l ? 1'b0 : (r_carry ^ w_cnext);
            r_zero  <= (w_result == '0);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out   = r_out;
  assign c_out = r_c_out;
  assign ovf   = r_ovf;
  assign zero  = r_zero;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_alu_serie.sv
// tb_alu_serie: directed and randomized checks of alu_serie at WIDTH=8 and
// WIDTH=16 against an arithmetic reference model.
module tb_alu_serie;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        st8, l8, cin8;
  logic [7:0]  a8, b8;
  logic [1:0]  s8;
  logic [7:0]  out8;
  logic        c8, v8, z8, busy8, done8;

  logic        st16, l16, cin16;
  logic [15:0] a16, b16;
  logic [1:0]  s16;
  logic [15:0] out16;
  logic        c16, v16, z16, busy16, done16;

  alu_serie #(.WIDTH(8), .CW(6)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .l(l8),
    .cin(cin8), .s(s8), .out(out8), .c_out(c8), .ovf(v8), .zero(z8),
    .busy(busy8), .done(done8)
  );

  alu_serie #(.WIDTH(16), .CW(6)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .a(a16), .b(b16), .l(l16),
    .cin(cin16), .s(s16), .out(out16), .c_out(c16), .ovf(v16), .zero(z16),
    .busy(busy16), .done(done16)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] last_out [2];
  logic        last_c   [2];
  logic        last_v   [2];
  logic        last_z   [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic, signed overflow from operand/result signs.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input bit l, input bit cin, input bit [1:0] s,
                                output logic [31:0] res, output bit c, output bit v);
    longint unsigned mask, x, y, full, am, bm;
    mask = (64'd1 << w) - 64'd1;
    am   = {32'd0, a} & mask;
    bm   = {32'd0, b} & mask;
    c    = 1'b0;
    v    = 1'b0;
    if (l) begin
      case (s)
        2'b00:   full = am & bm;
        2'b01:   full = am | bm;
        2'b10:   full = am ^ bm;
        default: full = (~am) & mask;
      endcase
      res = full[31:0];
    end else begin
      case (s)
        2'b00:   begin x = am; y = bm;           end
        2'b01:   begin x = am; y = (~bm) & mask; end
        2'b10:   begin x = am; y = 64'd0;        end
        default: begin x = bm; y = 64'd0;        end
      endcase
      full = x + y + {63'd0, cin};
      res  = 32'(full & mask);
      c    = full[w];
      v    = (x[w-1] == y[w-1]) && (full[w-1] != x[w-1]);
    end
  endfunction

  task automatic drive(input int w, input bit st, input logic [31:0] a, input logic [31:0] b,
                       input bit l, input bit cin, input bit [1:0] s);
    if (w == 8) begin
      st8 = st; a8 = a[7:0]; b8 = b[7:0]; l8 = l; cin8 = cin; s8 = s;
    end else begin
      st16 = st; a16 = a[15:0]; b16 = b[15:0]; l16 = l; cin16 = cin; s16 = s;
    end
  endtask

  task automatic sample(input int w, output logic [31:0] o, output logic c, output logic v,
                        output logic z, output logic bz, output logic dn);
    if (w == 8) begin
      o = {24'd0, out8}; c = c8; v = v8; z = z8; bz = busy8; dn = done8;
    end else begin
      o = {16'd0, out16}; c = c16; v = v16; z = z16; bz = busy16; dn = done16;
    end
  endtask

  // One operation: load edge, WIDTH bit edges, result checked in the done cycle.
  // hold keeps start high and scrambles a during RUN; chain starts in the done cycle.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                        input bit l, input bit cin, input bit [1:0] s,
                        input bit hold, input bit chain);
    logic [31:0] r, o;
    bit          ec, ev;
    logic        c, v, z, bz, dn;
    int          i;
    i = (w == 8) ? 0 : 1;
    model(w, a, b, l, cin, s, r, ec, ev);
    if (!chain) @(negedge clk);
    drive(w, 1'b1, a, b, l, cin, s);
    @(posedge clk); #1;
    sample(w, o, c, v, z, bz, dn);
    check1("load_busy", bz, 1'b1);
    check1("load_done", dn, 1'b0);
    check("load_hold_out", o, last_out[i]);
    if (hold) drive(w, 1'b1, ~a, b, l, cin, s);
    else      drive(w, 1'b0, a, b, l, cin, s);
    for (int k = 1; k <= w; k++) begin
      @(posedge clk); #1;
      sample(w, o, c, v, z, bz, dn);
      if (k < w) begin
        check1("run_busy", bz, 1'b1);
        check1("run_done", dn, 1'b0);
        check("run_hold_out", o, last_out[i]);
        check1("run_hold_c", c, last_c[i]);
        check1("run_hold_z", z, last_z[i]);
      end else begin
        check1("end_done", dn, 1'b1);
        check1("end_busy", bz, 1'b0);
        check("end_out", o, r);
        check1("end_c_out", c, ec);
        check1("end_ovf", v, ev);
        check1("end_zero", z, (r == 32'd0));
        last_out[i] = r;
        last_c[i]   = ec;
        last_v[i]   = ev;
        last_z[i]   = (r == 32'd0);
      end
    end
    $display("op w=%0d l=%0d s=%0d a=%h b=%h cin=%0d -> out=%h c=%0d v=%0d z=%0d (exp out=%h c=%0d v=%0d)",
             w, l, s, a, b, cin, o, c, v, z, r, ec, ev);
  endtask

  task automatic check_reset_state(input int w, input string tag);
    logic [31:0] o;
    logic        c, v, z, bz, dn;
    sample(w, o, c, v, z, bz, dn);
    check({tag, "_out"}, o, 32'd0);
    check1({tag, "_c"}, c, 1'b0);
    check1({tag, "_v"}, v, 1'b0);
    check1({tag, "_z"}, z, 1'b1);
    check1({tag, "_busy"}, bz, 1'b0);
    check1({tag, "_done"}, dn, 1'b0);
  endtask

  task automatic set_reset_model();
    for (int i = 0; i < 2; i++) begin
      last_out[i] = 32'd0; last_c[i] = 1'b0; last_v[i] = 1'b0; last_z[i] = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rl, rc;
    bit [1:0]    rs;
    logic [31:0] o;
    logic        c, v, z, bz, dn;

    rst_n = 1'b0;
    drive(8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00);
    drive(16, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00);
    set_reset_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state(8, "rst8");
    check_reset_state(16, "rst16");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    run_op(8, 32'h3C, 32'hA5, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    run_op(8, 32'hFF, 32'h01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    run_op(8, 32'h7F, 32'h01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    run_op(8, 32'h10, 32'h20, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    run_op(8, 32'hF0, 32'hAA, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    run_op(8, 32'h80, 32'h00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
    run_op(8, 32'h7F, 32'h00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    run_op(8, 32'h5A, 32'h00, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);

    // start held high with a scrambled mid-operation, then back-to-back op
    run_op(8, 32'h21, 32'h42, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    run_op(8, 32'hC3, 32'h0F, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);

    // Asynchronous reset while bit 4 is in flight
    @(negedge clk);
    drive(8, 1'b1, 32'h55, 32'h33, 1'b0, 1'b0, 2'b00);
    @(posedge clk); #1;
    drive(8, 1'b0, 32'h55, 32'h33, 1'b0, 1'b0, 2'b00);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    set_reset_model();
    check_reset_state(8, "async_rst8");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      sample(8, o, c, v, z, bz, dn);
      check1("post_rst_done", dn, 1'b0);
      check1("post_rst_busy", bz, 1'b0);
    end
    run_op(8, 32'h3C, 32'hA5, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // WIDTH=16 directed
    run_op(16, 32'hFFFF, 32'h0001, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    run_op(16, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // Randomized operations
    for (int n = 0; n < 24; n++) begin
      ra = $urandom; rb = $urandom;
      rl = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      rs = 2'($urandom_range(0, 3));
      run_op(8, ra, rb, rl, rc, rs, 1'b0, (n % 3) == 2);
    end
    for (int n = 0; n < 8; n++) begin
      ra = $urandom; rb = $urandom;
      rl = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      rs = 2'($urandom_range(0, 3));
      run_op(16, ra, rb, rl, rc, rs, 1'b0, 1'b0);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
